puf_eval_ctrl: RTL and testbench

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

---
 rtl/puf_eval_ctrl_if.sv | 27 ++
 rtl/puf_eval_ctrl.sv | 148 ++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_eval_ctrl_if.sv
// Signal bundle between the arbiter-PUF evaluation controller and its environment:
// request side (start/seed), arbiter chain side (challenge, launch, clear, response)
// and response-word side (word/valid/ready).
interface puf_eval_ctrl_if;
   logic        start;
   logic [7:0]  seed;
   logic [7:0]  chal_out;
   logic        puf_launch;
   logic        puf_clr;
   logic        resp_in;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic        busy;

   // Controller side.
   modport master (
      input  start, seed, resp_in, word_ready,
      output chal_out, puf_launch, puf_clr, word_out, word_valid, busy
   );

   // Requester / arbiter chain / word consumer side.
   modport slave (
      output start, seed, resp_in, word_ready,
      input  chal_out, puf_launch, puf_clr, word_out, word_valid, busy
   );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: drives LFSR challenges into an arbiter chain,
// launches and settles each evaluation, samples the synchronized response and packs
// 32 response bits (MSB first) into a word handed out with a valid/ready handshake.
// Optional build macro PUF_MAJORITY_VOTE_EN: evaluate every challenge 5 times and
// take the majority as the response bit.
module puf_eval_ctrl #(
   parameter int unsigned SETTLE_CYC = 4
) (
   input logic            clk,
   input logic            rst,
   puf_eval_ctrl_if.master bus
);

   // SETTLE also absorbs the 2-cycle synchronizer latency.
   localparam int unsigned SettleLen = SETTLE_CYC + 2;
   localparam int unsigned SettleW   = $clog2(SettleLen);

   typedef enum logic [2:0] {
      StIdle, StClear, StLaunch, StSettle, StSample, StAccum, StOutput
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          lfsr_q;
   logic [7:0]          lfsr_next;
   logic [4:0]          cnt_q;
   logic [31:0]         word_q;
   logic [SettleW-1:0]  settle_q;
   logic                sync1_q, sync2_q;
   logic                acc_bit;
   logic                settle_done;
   logic                last_pass;

`ifdef PUF_MAJORITY_VOTE_EN
   logic [2:0]          pass_q;
   logic [2:0]          ones_q;
   assign acc_bit   = (ones_q >= 3'd3);
   assign last_pass = (pass_q == 3'd4);
`else
   logic                bit_q;
   assign acc_bit   = bit_q;
   assign last_pass = 1'b1;
`endif

   // Galois LFSR, x^8+x^6+x^5+x^4+1 (right-shift form, tap mask 8'hB8); 0 is never reached
   // from a nonzero state.
   assign lfsr_next   = lfsr_q[0] ? ({1'b0, lfsr_q[7:1]} ^ 8'hB8) : {1'b0, lfsr_q[7:1]};
   assign settle_done = (settle_q == SettleW'(SettleLen - 1));

   // Two-flop synchronizer for the asynchronous arbiter response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.resp_in;
         sync2_q <= sync1_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // FSM next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.start) state_d = StClear;
         StClear:  state_d = StLaunch;
         StLaunch: state_d = StSettle;
         StSettle: if (settle_done) state_d = StSample;
         StSample: state_d = last_pass ? StAccum : StClear;
         StAccum:  state_d = (cnt_q == 5'd31) ? StOutput : StClear;
         StOutput: if (bus.word_ready) state_d = bus.start ? StClear : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs; the challenge is the live LFSR value, which only moves in ACCUM.
   always_comb begin
      bus.busy       = (state_q != StIdle);
      bus.puf_clr    = (state_q == StClear);
      bus.puf_launch = (state_q == StLaunch) || (state_q == StSettle);
      bus.word_valid = (state_q == StOutput);
      bus.chal_out   = lfsr_q;
      bus.word_out   = word_q;
   end

   // Datapath: LFSR, bit counter, settle timer, response capture and word packing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q   <= 8'h00;
         cnt_q    <= 5'd0;
         word_q   <= 32'd0;
         settle_q <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
         pass_q   <= 3'd0;
         ones_q   <= 3'd0;
`else
         bit_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  lfsr_q <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                  cnt_q  <= 5'd0;
                  word_q <= 32'd0;
`ifdef PUF_MAJORITY_VOTE_EN
                  pass_q <= 3'd0;
                  ones_q <= 3'd0;
`endif
               end
            end
            StLaunch: settle_q <= '0;
            StSettle: settle_q <= settle_q + 1'b1;
            StSample: begin
`ifdef PUF_MAJORITY_VOTE_EN
               pass_q <= pass_q + 3'd1;
               ones_q <= ones_q + {2'b00, sync2_q};
`else
               bit_q  <= sync2_q;
`endif
            end
            StAccum: begin
               word_q <= {word_q[30:0], acc_bit};
               lfsr_q <= lfsr_next;
               cnt_q  <= cnt_q + 5'd1;
`ifdef PUF_MAJORITY_VOTE_EN
               pass_q <= 3'd0;
               ones_q <= 3'd0;
`endif
            end
            StOutput: begin
               // Back-to-back words keep the LFSR running; only the word restarts.
               if (bus.word_ready && bus.start) begin
                  word_q <= 32'd0;
                  cnt_q  <= 5'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: reset state, all-ones word timing, output hold,
// LFSR-driven response word, zero-seed challenge sequence, and mid-word reset.
module tb_puf_eval_ctrl;

   localparam int unsigned S = 4;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int BIT_CYC = 5 * (S + 5) + 1;
   localparam int CLR_GAP = S + 5;
`else
   localparam int BIT_CYC = S + 6;
   localparam int CLR_GAP = S + 6;
`endif

   logic clk;
   logic rst;
   logic resp_mode;
   logic resp_const;

   puf_eval_ctrl_if bus ();

   puf_eval_ctrl #(.SETTLE_CYC(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.resp_in = resp_mode ? bus.chal_out[0] : resp_const;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Monitor bookkeeping.
   int         cyc = 0;
   int         last_clr = -1000;
   int         clr_cnt = 0;
   int         overlap_viol = 0;
   int         chal_viol = 0;
   int         gap_viol = 0;
   logic [7:0] chal_ref = 8'h00;
   logic       collect = 1'b0;
   logic [7:0] chals[$];

   // Protocol monitor sampled on the falling edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         last_clr <= -1000;
      end else begin
         if (bus.puf_clr && bus.puf_launch) overlap_viol <= overlap_viol + 1;
         if (bus.puf_clr) begin
            clr_cnt  <= clr_cnt + 1;
            chal_ref <= bus.chal_out;
            if (cyc - last_clr < CLR_GAP) gap_viol <= gap_viol + 1;
            last_clr <= cyc;
            if (collect) chals.push_back(bus.chal_out);
         end
         if (bus.puf_launch && bus.chal_out !== chal_ref) chal_viol <= chal_viol + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic [7:0] r;
      r = {1'b0, v[7:1]};
      if (v[0]) r = r ^ 8'hB8;
      return r;
   endfunction

   initial begin
      int         n;
      int         k;
      int         clr0;
      int         cnt_bad;
      logic [31:0] wsave;
      logic [31:0] wexp;
      logic [7:0]  v;
      logic        seen[256];

      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.seed   = 8'h00;
      bus.word_ready = 1'b0;
      resp_mode  = 1'b0;
      resp_const = 1'b0;

      // Reset state.
      #12;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_clr", {31'd0, bus.puf_clr}, 32'd0);
      check("rst_launch", {31'd0, bus.puf_launch}, 32'd0);
      check("rst_valid", {31'd0, bus.word_valid}, 32'd0);
      check("rst_chal", {24'd0, bus.chal_out}, 32'd0);
      check("rst_word", bus.word_out, 32'd0);
      #5 rst = 1'b1;
      tick();

      // All-ones response, start dropped early, latency to word_valid.
      resp_const = 1'b1;
      bus.seed   = 8'h01;
      bus.start  = 1'b1;
      tick();
      check("t1_busy", {31'd0, bus.busy}, 32'd1);
      check("t1_clr", {31'd0, bus.puf_clr}, 32'd1);
      check("t1_chal", {24'd0, bus.chal_out}, 32'h01);
      n = 0;
      while (!bus.word_valid && n < 2000) begin
         tick();
         n++;
         if (n == 3) bus.start = 1'b0;
      end
      check("t1_latency", n, 32 * BIT_CYC);
      check("t1_word", bus.word_out, 32'hFFFF_FFFF);

      // Consumer stalls: word and valid hold, no new evaluation.
      wsave   = bus.word_out;
      clr0    = clr_cnt;
      cnt_bad = 0;
      repeat (50) begin
         tick();
         if (bus.word_valid !== 1'b1 || bus.word_out !== wsave) cnt_bad++;
      end
      check("t1_hold", cnt_bad, 0);
      check("t1_hold_noclr", clr_cnt - clr0, 0);
      bus.word_ready = 1'b1;
      tick();
      check("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("t1_idle_valid", {31'd0, bus.word_valid}, 32'd0);

      // Response equals challenge LSB; word is the LFSR LSB sequence, first bit in MSB.
      resp_mode = 1'b1;
      bus.seed  = 8'hA5;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!bus.word_valid && n < 2000) begin
         tick();
         n++;
      end
      v    = 8'hA5;
      wexp = 32'd0;
      for (int i = 0; i < 32; i++) begin
         wexp = {wexp[30:0], v[0]};
         v    = lfsr_step(v);
      end
      check("t2_valid", {31'd0, bus.word_valid}, 32'd1);
      check("t2_word", bus.word_out, wexp);
      tick();

      // Zero seed: 255 consecutive challenges across back-to-back words.
      resp_mode  = 1'b0;
      resp_const = 1'b0;
      bus.seed   = 8'h00;
      bus.start  = 1'b1;
      collect    = 1'b1;
      n = 0;
      while (chals.size() < 255 && n < 6000) begin
         tick();
         n++;
      end
      collect   = 1'b0;
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 2000) begin
         tick();
         n++;
      end
      check("t3_idle", {31'd0, bus.busy}, 32'd0);
      check("t3_count_ok", {31'd0, (chals.size() >= 255)}, 32'd1);
      check("t3_first", {24'd0, chals[0]}, 32'h01);
      foreach (seen[i]) seen[i] = 1'b0;
      cnt_bad = 0;
      k       = 0;
      v       = 8'h01;
      for (int i = 0; i < 255 && i < chals.size(); i++) begin
         if (chals[i] == 8'h00 || seen[chals[i]]) cnt_bad++;
         seen[chals[i]] = 1'b1;
         if (chals[i] !== v) k++;
         v = lfsr_step(v);
      end
      check("t3_distinct", cnt_bad, 0);
      check("t3_model", k, 0);

      // Reset during SETTLE of bit 17.
      resp_const = 1'b1;
      bus.seed   = 8'h01;
      bus.start  = 1'b1;
      tick();
      k = bus.puf_clr ? 1 : 0;
      n = 0;
      while (k < 18 && n < 1000) begin
         tick();
         n++;
         if (bus.puf_clr) k++;
      end
      check("t4_reach17", k, 18);
      tick();
      tick();
      check("t4_settle", {31'd0, bus.puf_launch}, 32'd1);
      bus.start = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("t4_busy", {31'd0, bus.busy}, 32'd0);
      check("t4_launch", {31'd0, bus.puf_launch}, 32'd0);
      check("t4_clr", {31'd0, bus.puf_clr}, 32'd0);
      check("t4_valid", {31'd0, bus.word_valid}, 32'd0);
      check("t4_chal", {24'd0, bus.chal_out}, 32'd0);
      check("t4_word", bus.word_out, 32'd0);
      #3 rst = 1'b1;
      clr0    = clr_cnt;
      cnt_bad = 0;
      repeat (50) begin
         tick();
         if (bus.busy || bus.puf_launch || bus.puf_clr || bus.word_valid) cnt_bad++;
      end
      check("t4_quiet", cnt_bad, 0);
      check("t4_noclr", clr_cnt - clr0, 0);

      // Whole-run protocol properties.
      check("overlap", overlap_viol, 0);
      check("chal_stable", chal_viol, 0);
      check("clr_gap", gap_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
